// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - iterative unsigned shift-add multiplier sharing the CPU ALU
module mult_seq_ctrl #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] multiplicand_i,
  input  logic [DATA_W-1:0] multiplier_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              alu_req_o,
  input  logic              alu_grant_i,
  output logic [3:0]        alu_ctrl_o,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  input  logic [DATA_W-1:0] alu_result_i
);

  localparam logic [3:0]       ALU_ADD  = 4'b0010;
  localparam logic [3:0]       ALU_NOP  = 4'b1111;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mcand_q, hi_q, lo_q;
  logic [DATA_W-1:0] hi_d, lo_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q, done_q;
  logic              advance;
  logic              carry;

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state, ALU request decode and the shifted partial product for this iteration
  always_comb begin
    state_d    = state_q;
    alu_req_o  = 1'b0;
    alu_ctrl_o = ALU_NOP;
    alu_src1_o = '0;
    alu_src2_o = '0;
    advance    = 1'b0;
    carry      = 1'b0;
    hi_d       = hi_q;
    lo_d       = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (lo_q[0]) begin
          // Multiplier bit set: add mcand into hi, but only once the ALU is ours
          alu_req_o  = 1'b1;
          alu_ctrl_o = ALU_ADD;
          alu_src1_o = hi_q;
          alu_src2_o = mcand_q;
          if (alu_grant_i) begin
            // The ALU has no carry-out; a wrapped sum is smaller than either addend
            carry        = (alu_result_i < hi_q);
            {hi_d, lo_d} = {carry, alu_result_i, lo_q[DATA_W-1:1]};
            advance      = 1'b1;
          end
        end else begin
          {hi_d, lo_d} = {1'b0, hi_q, lo_q[DATA_W-1:1]};
          advance      = 1'b1;
        end
        if (advance && (cnt_q == CNT_LAST)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Operand capture on accepted start, then one shift per completed iteration
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else if ((state_q == S_IDLE) && start_i) begin
      mcand_q <= multiplicand_i;
      hi_q    <= '0;
      lo_q    <= multiplier_i;
      cnt_q   <= '0;
    end else if (advance) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  // Handshake flags registered from the next state so they line up with RUN/DONE
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d != S_IDLE);
      done_q <= (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - directed self-checking bench for mult_seq_ctrl
module tb_mult_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] mcand;
  logic [31:0] mplier;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        alu_req;
  logic        alu_grant;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_result;

  int total = 0;
  int bad   = 0;

  mult_seq_ctrl #(.DATA_W(32), .CNT_W(5)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .multiplicand_i(mcand),
    .multiplier_i  (mplier),
    .busy_o        (busy),
    .done_o        (done),
    .hi_o          (hi),
    .lo_o          (lo),
    .alu_req_o     (alu_req),
    .alu_grant_i   (alu_grant),
    .alu_ctrl_o    (alu_ctrl),
    .alu_src1_o    (alu_src1),
    .alu_src2_o    (alu_src2),
    .alu_result_i  (alu_result)
  );

  // Shared ALU model: add on 4'b0010, otherwise zero
  assign alu_result = (alu_ctrl == 4'b0010) ? (alu_src1 + alu_src2) : 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_done"}, {63'd0, done}, 64'd0);
    check({tag, "_req"},  {63'd0, alu_req}, 64'd0);
    check({tag, "_ctrl"}, {60'd0, alu_ctrl}, 64'hF);
    check({tag, "_src1"}, {32'd0, alu_src1}, 64'd0);
    check({tag, "_src2"}, {32'd0, alu_src2}, 64'd0);
    check({tag, "_hi"},   {32'd0, hi}, 64'd0);
    check({tag, "_lo"},   {32'd0, lo}, 64'd0);
  endtask

  // One multiply: lat = clock edges from the start-sampling edge to the done cycle.
  // stall: grant withheld for that many cycles on the first request.
  // pulse_at: extra start pulse in that RUN cycle. abort_at: async reset in that cycle.
  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int stall, input int pulse_at, input int abort_at,
                          output int lat, output int busy_cnt, output int req_cnt);
    int          n;
    int          stall_left;
    logic        got_done;
    logic [31:0] s1, s2;
    lat        = -1;
    busy_cnt   = 0;
    req_cnt    = 0;
    stall_left = stall;
    got_done   = 1'b0;
    s1         = '0;
    s2         = '0;
    @(posedge clk);
    #1;
    check({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_idle_done"}, {63'd0, done}, 64'd0);
    mcand  = a;
    mplier = b;
    start  = 1'b1;
    for (n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) start = 1'b0;
      if (n == pulse_at) begin
        start  = 1'b1;
        mcand  = 32'd100;
        mplier = 32'd100;
      end
      if (n == pulse_at + 1) start = 1'b0;
      if (n == abort_at) begin
        #3;
        rst = 1'b1;
        #1;
        check_reset_outputs({tag, "_async"});
        break;
      end
      if (alu_req && stall_left > 0) begin
        if (stall_left == stall) begin
          s1 = alu_src1;
          s2 = alu_src2;
        end else begin
          check({tag, "_stall_src1"}, {32'd0, alu_src1}, {32'd0, s1});
          check({tag, "_stall_src2"}, {32'd0, alu_src2}, {32'd0, s2});
        end
        check({tag, "_stall_req"},  {63'd0, alu_req}, 64'd1);
        check({tag, "_stall_ctrl"}, {60'd0, alu_ctrl}, 64'h2);
        alu_grant  = 1'b0;
        stall_left = stall_left - 1;
      end else begin
        alu_grant = 1'b1;
      end
      @(negedge clk);
      if (busy)    busy_cnt++;
      if (alu_req) req_cnt++;
      if (done) begin
        lat      = n;
        got_done = 1'b1;
        break;
      end
    end
    alu_grant = 1'b1;
    if (abort_at == 0 && !got_done) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  int lat, bc, rc;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    mcand     = '0;
    mplier    = '0;
    alu_grant = 1'b1;
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: basic product
    run_mult("basic", 32'd3, 32'd5, 0, 0, 0, lat, bc, rc);
    check("basic_lat",  lat, 33);
    check("basic_busy", bc, 33);
    check("basic_hi",   {32'd0, hi}, 64'd0);
    check("basic_lo",   {32'd0, lo}, 64'd15);

    // 2: carry out of the 32-bit add
    run_mult("carry", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, lat, bc, rc);
    check("carry_lat", lat, 33);
    check("carry_hi",  {32'd0, hi}, 64'hFFFF_FFFE);
    check("carry_lo",  {32'd0, lo}, 64'h0000_0001);
    check("carry_req", rc, 32);

    // 3: zero multiplier never touches the ALU
    run_mult("zero", 32'h1234_5678, 32'd0, 0, 0, 0, lat, bc, rc);
    check("zero_lat", lat, 33);
    check("zero_req", rc, 0);
    check("zero_hi",  {32'd0, hi}, 64'd0);
    check("zero_lo",  {32'd0, lo}, 64'd0);

    // 4: four withheld grants on the first request
    run_mult("stall", 32'd7, 32'h8000_0001, 4, 0, 0, lat, bc, rc);
    check("stall_lat",  lat, 37);
    check("stall_busy", bc, 37);
    check("stall_hi",   {32'd0, hi}, 64'd3);
    check("stall_lo",   {32'd0, lo}, 64'h8000_0007);

    // 5: start while busy is ignored, start right after done is taken
    run_mult("busyp", 32'd2, 32'd9, 0, 10, 0, lat, bc, rc);
    check("busyp_lat", lat, 33);
    check("busyp_hi",  {32'd0, hi}, 64'd0);
    check("busyp_lo",  {32'd0, lo}, 64'd18);
    run_mult("b2b", 32'd11, 32'd13, 0, 0, 0, lat, bc, rc);
    check("b2b_lat", lat, 33);
    check("b2b_lo",  {32'd0, lo}, 64'd143);

    // 6: asynchronous reset mid-operation, then a clean multiply
    run_mult("abort", 32'd1000, 32'd1000, 0, 0, 15, lat, bc, rc);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bc  = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) bc++;
    end
    check("abort_no_done", bc, 0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    run_mult("after", 32'd6, 32'd7, 0, 0, 0, lat, bc, rc);
    check("after_lat", lat, 33);
    check("after_hi",  {32'd0, hi}, 64'd0);
    check("after_lo",  {32'd0, lo}, 64'd42);

    // Product holds in IDLE once done has passed
    repeat (3) @(posedge clk);
    #1;
    check("hold_lo",   {32'd0, lo}, 64'd42);
    check("hold_busy", {63'd0, busy}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
Name: mult_seq_ctrl

Overview:
Iterative unsigned 32x32 multiply sequencer for the CPU's multu/HI/LO path. It runs shift-add over 32 iterations and borrows the shared combinational ALU for every add. It requests the ALU through a req/grant handshake, so the main datapath keeps priority. It drives the 4-bit ALU control code directly and produces a 64-bit product in HI/LO with a start/busy/done handshake.

Parameters:
DATA_W, 32, operand and ALU width
CNT_W, 5, iteration counter width (2^CNT_W = DATA_W iterations)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous, active-high reset
start_i  input  1  begin multiply; sampled only in IDLE
multiplicand_i  input  DATA_W  operand A, captured on accepted start
multiplier_i  input  DATA_W  operand B, captured on accepted start
busy_o  output  1  high from the cycle after accepted start through the DONE cycle
done_o  output  1  one-cycle pulse when HI/LO become valid
hi_o  output  DATA_W  product[63:32]
lo_o  output  DATA_W  product[31:0]
alu_req_o  output  1  request for the shared ALU this cycle
alu_grant_i  input  1  ALU granted this cycle; ALU result is valid in the same cycle
alu_ctrl_o  output  4  ALU control code: 4'b0010 (add) when requesting, else 4'b1111
alu_src1_o  output  DATA_W  ALU operand 1: hi register when requesting, else 0
alu_src2_o  output  DATA_W  ALU operand 2: multiplicand register when requesting, else 0
alu_result_i  input  DATA_W  combinational ALU result

Behaviour:
- States: IDLE, RUN, DONE. Internal registers: mcand, hi, lo, cnt.
- Reset (async, any state): state=IDLE; mcand, hi, lo, cnt = 0; busy_o=0; done_o=0; alu_req_o=0; alu_ctrl_o=4'b1111; alu_src1_o, alu_src2_o = 0. Reset mid-RUN aborts the operation with no done_o pulse.
- IDLE:
  - start_i=1 → next cycle RUN, with mcand=multiplicand_i, hi=0, lo=multiplier_i, cnt=0.
  - hi_o/lo_o keep the previous product (0 after reset).
- RUN, lo[0]=0:
  - No request.
  - {hi,lo} <= {1'b0,hi,lo} >> 1; cnt++.
- RUN, lo[0]=1:
  - alu_req_o=1, alu_ctrl_o=4'b0010, src1=hi, src2=mcand.
  - If alu_grant_i=1: sum=alu_result_i, carry=(sum < hi), unsigned compare. Then {hi,lo} <= {carry,sum,lo} >> 1; cnt++.
  - If alu_grant_i=0: stall. All registers hold and the request stays asserted.
- RUN exit: when the iteration with cnt=DATA_W-1 completes, next state is DONE. No further ALU request is issued.
- DONE: done_o=1 and busy_o=1 for exactly one cycle, then IDLE.
- hi_o/lo_o are driven from the hi/lo registers. They are valid when done_o=1 and stay stable in IDLE until the next accepted start.
- Latency with grant always high: start sampled at edge T; RUN occupies T+1..T+32; done_o high in cycle T+33. Each withheld grant adds exactly one cycle.
- start_i in RUN or DONE is ignored (no queueing). start_i in the cycle after DONE (IDLE) is accepted.
- alu_grant_i while alu_req_o=0 is ignored.
- Outputs are registered, except alu_req_o, alu_ctrl_o and alu_src*_o, which are decoded from state and registers (no input-to-output combinational path).

Test Plan:
(The bench models the ALU as combinational: code 4'b0010 → src1+src2 mod 2^32.)
1. Basic product: grant tied high, start with A=3, B=5 → done_o pulses at start+33 cycles; hi_o=0, lo_o=15; busy_o high for exactly 33 cycles.
2. Carry path: grant high, A=B=32'hFFFFFFFF → hi_o=32'hFFFFFFFE, lo_o=32'h00000001.
3. Zero operand: A=32'h12345678, B=0 → alu_req_o never asserted; hi_o=lo_o=0; done at start+33.
4. Grant stall: A=7, B=32'h80000001, grant withheld for 4 cycles on the first request → alu_req_o held high and ALU outputs stable during the stall; done at start+37; hi_o=3, lo_o=32'h80000007.
5. Busy protection: start A=2, B=9, then pulse start_i with A=100, B=100 at cycle start+10 → second start ignored; result lo_o=18; a new start one cycle after done_o is accepted.
6. Reset mid-op: assert rst_i asynchronously at start+15 (between clock edges) → all outputs reach reset values immediately without a clock edge; no done_o pulse; a following start with A=6, B=7 yields lo_o=42.
